// File: rtl/ntt_pkg.sv
// Shared NTT constants, types and the write-back routing helpers used by the butterfly datapath.
// The upstream address generator keys off the same len constants.
package ntt_pkg;

  localparam int NUM_BU      = 8;
  localparam int NUM_SLOT    = 2 * NUM_BU;
  localparam int COEFF_WIDTH = 12;

  typedef logic [COEFF_WIDTH-1:0] coeff_t;
  typedef coeff_t lane_arr_t [NUM_BU];
  typedef coeff_t slot_arr_t [NUM_SLOT];

  localparam logic [7:0] LEN_MIN = 8'd2;
  localparam logic [7:0] LEN_32  = 8'd32;
  localparam logic [7:0] LEN_64  = 8'd64;
  localparam logic [7:0] LEN_128 = 8'd128;

  // Legal layer lengths are the powers of two from 2 to 128.
  function automatic logic len_legal(input logic [7:0] len);
    return (len >= LEN_MIN) && ((len & (len - 8'd1)) == 8'd0);
  endfunction

  // Source lane for write slot (slot = 2*bram + port): 0..7 selects X_k, 8..15 selects Y_(k-8).
  function automatic logic [3:0] route_src(input logic [7:0] len, input int slot);
    logic [3:0] s;
    logic [3:0] src;
    s = 4'(slot);
    if (len == LEN_128)
      src = s;
    else if (len == LEN_64)
      src = {s[1], s[3], s[0], s[2]};
    else if ((len == LEN_32) || (s[3:2] != 2'b00))
      src = {s[1], s[3], s[2], s[0]};
    else
      src = {s[0], 2'b00, s[1]};
    return src;
  endfunction

  function automatic slot_arr_t route_wb(input logic [7:0] len, input lane_arr_t x, input lane_arr_t y);
    slot_arr_t  r;
    logic [3:0] src;
    for (int i = 0; i < NUM_SLOT; i++) begin
      src  = route_src(len, i);
      r[i] = src[3] ? y[src[2:0]] : x[src[2:0]];
    end
    return r;
  endfunction

endpackage

// File: rtl/ntt_sideband_delay.sv
// Fixed-depth shift register carrying a beat's sideband alongside the butterfly pipeline.
// Synchronous reset and clear both empty every stage.
module ntt_sideband_delay #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      logic [WIDTH-1:0] stage_reg;
      if (gi == 0) begin : g_head
        always_ff @(posedge clk_i) begin
          if (rst_i || clr_i) stage_reg <= '0;
          else                stage_reg <= d_i;
        end
      end else begin : g_tail
        always_ff @(posedge clk_i) begin
          if (rst_i || clr_i) stage_reg <= '0;
          else                stage_reg <= g_stage[gi-1].stage_reg;
        end
      end
    end
  endgenerate

  assign q_o = g_stage[DEPTH-1].stage_reg;

endmodule

// File: rtl/bu_writeback_router.sv
// Selects NTT/iNTT butterfly results, undoes the chooser permutation for the beat's len and
// drives the 8 dual-port BRAM write ports; counts beats per layer and flags illegal len.
module bu_writeback_router
  import ntt_pkg::*;
#(
  parameter int DATA_WIDTH      = 13,
  parameter int ADDR_WIDTH      = 5,
  parameter int BU_LAT          = 4,
  parameter int BEATS_PER_LAYER = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  valid_i,
  input  logic [7:0]            len_i,
  input  logic                  is_ntt_i,
  input  logic [ADDR_WIDTH-1:0] addr_a_i,
  input  logic [ADDR_WIDTH-1:0] addr_b_i,
  input  logic                  flush_i,
  input  logic [DATA_WIDTH-2:0] a_ntt_i   [NUM_BU],
  input  logic [DATA_WIDTH-2:0] b_ntt_i   [NUM_BU],
  input  logic [DATA_WIDTH-2:0] a_intt_i  [NUM_BU],
  input  logic [DATA_WIDTH-2:0] b_intt_i  [NUM_BU],
  output logic [DATA_WIDTH-2:0] wdata_a_o [NUM_BU],
  output logic [DATA_WIDTH-2:0] wdata_b_o [NUM_BU],
  output logic [ADDR_WIDTH-1:0] waddr_a_o,
  output logic [ADDR_WIDTH-1:0] waddr_b_o,
  output logic                  we_o,
  output logic                  layer_done_o,
  output logic                  len_err_o
);

  localparam int CW    = DATA_WIDTH - 1;
  localparam int SB_W  = 10 + 2 * ADDR_WIDTH;
  localparam int CNT_W = (BEATS_PER_LAYER > 1) ? $clog2(BEATS_PER_LAYER) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS_PER_LAYER - 1);

  logic [SB_W-1:0]       sb_q;
  logic                  d_valid;
  logic [7:0]            d_len;
  logic                  d_is_ntt;
  logic [ADDR_WIDTH-1:0] d_addr_a;
  logic [ADDR_WIDTH-1:0] d_addr_b;

  // Stage BU_LAT of the delay line lines up with the butterfly outputs of the same beat.
  ntt_sideband_delay #(
    .DEPTH (BU_LAT),
    .WIDTH (SB_W)
  ) u_sideband (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (flush_i),
    .d_i   ({valid_i, len_i, is_ntt_i, addr_a_i, addr_b_i}),
    .q_o   (sb_q)
  );

  assign {d_valid, d_len, d_is_ntt, d_addr_a, d_addr_b} = sb_q;

  logic [CW-1:0] lane_x    [NUM_BU];
  logic [CW-1:0] lane_y    [NUM_BU];
  logic [CW-1:0] slot_data [NUM_SLOT];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BU; gi++) begin : g_lane
      assign lane_x[gi] = d_is_ntt ? a_ntt_i[gi] : a_intt_i[gi];
      assign lane_y[gi] = d_is_ntt ? b_ntt_i[gi] : b_intt_i[gi];
    end
    for (gi = 0; gi < NUM_SLOT; gi++) begin : g_slot
      logic [3:0] src;
      assign src           = route_src(d_len, gi);
      assign slot_data[gi] = src[3] ? lane_y[src[2:0]] : lane_x[src[2:0]];
    end
  endgenerate

  logic             len_ok;
  logic             write_fire;
  logic [CNT_W-1:0] beat_cnt_reg;

  assign len_ok     = len_legal(d_len);
  assign write_fire = d_valid && len_ok;

  // Flush clears the output stage too, so nothing writes in the cycle after a flush.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      we_o         <= 1'b0;
      layer_done_o <= 1'b0;
      len_err_o    <= 1'b0;
      waddr_a_o    <= '0;
      waddr_b_o    <= '0;
      beat_cnt_reg <= '0;
      for (int j = 0; j < NUM_BU; j++) begin
        wdata_a_o[j] <= '0;
        wdata_b_o[j] <= '0;
      end
    end else begin
      we_o         <= write_fire;
      layer_done_o <= write_fire && (beat_cnt_reg == LAST_BEAT);
      len_err_o    <= d_valid && !len_ok;
      waddr_a_o    <= write_fire ? d_addr_a : '0;
      waddr_b_o    <= write_fire ? d_addr_b : '0;
      for (int j = 0; j < NUM_BU; j++) begin
        wdata_a_o[j] <= write_fire ? slot_data[2*j]   : '0;
        wdata_b_o[j] <= write_fire ? slot_data[2*j+1] : '0;
      end
      if (write_fire)
        beat_cnt_reg <= (beat_cnt_reg == LAST_BEAT) ? '0 : beat_cnt_reg + 1'b1;
    end
  end

endmodule

// File: tb/tb_bu_writeback_router.sv
// Randomised plus directed bench for bu_writeback_router against a cycle-timeline reference model.
module tb_bu_writeback_router;

  localparam int NCYC  = 700;
  localparam int LAT   = 4;
  localparam int BEATS = 16;
  localparam int CW    = 12;
  localparam int AW    = 5;

  logic          clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, valid, is_ntt, flush;
  logic [7:0]    len;
  logic [AW-1:0] addr_a, addr_b;
  logic [CW-1:0] a_ntt [8], b_ntt [8], a_intt [8], b_intt [8];
  logic [CW-1:0] wdata_a [8], wdata_b [8];
  logic [AW-1:0] waddr_a, waddr_b;
  logic          we, layer_done, len_err;

  bu_writeback_router #(
    .DATA_WIDTH(13), .ADDR_WIDTH(AW), .BU_LAT(LAT), .BEATS_PER_LAYER(BEATS)
  ) dut (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .len_i(len), .is_ntt_i(is_ntt),
    .addr_a_i(addr_a), .addr_b_i(addr_b), .flush_i(flush),
    .a_ntt_i(a_ntt), .b_ntt_i(b_ntt), .a_intt_i(a_intt), .b_intt_i(b_intt),
    .wdata_a_o(wdata_a), .wdata_b_o(wdata_b), .waddr_a_o(waddr_a), .waddr_b_o(waddr_b),
    .we_o(we), .layer_done_o(layer_done), .len_err_o(len_err)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Stimulus plan, which doubles as the input history for the model.
  bit            p_rst [NCYC], p_valid [NCYC], p_ntt [NCYC], p_flush [NCYC];
  logic [7:0]    p_len [NCYC];
  logic [AW-1:0] p_aa [NCYC], p_ab [NCYC];
  logic [CW-1:0] p_ant [NCYC][8], p_bnt [NCYC][8], p_ait [NCYC][8], p_bit [NCYC][8];

  // Routing table rows: 128, 64, 32, <=16. Entry = source lane, 0..7 = X_k, 8..15 = Y_(k-8).
  int route_tab [4][16];
  logic [7:0] bad_lens [6];

  function automatic bit len_ok(input logic [7:0] l);
    for (int e = 1; e <= 7; e++)
      if (l == 8'(1 << e)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int tab_row(input logic [7:0] l);
    if (l == 8'd128) return 0;
    if (l == 8'd64)  return 1;
    if (l == 8'd32)  return 2;
    return 3;
  endfunction

  task automatic plan_beat(input int c, input logic [7:0] l, input bit ntt, input logic [AW-1:0] aa, input logic [AW-1:0] ab);
    p_valid[c] = 1'b1; p_len[c] = l; p_ntt[c] = ntt; p_aa[c] = aa; p_ab[c] = ab;
  endtask

  initial begin
    int            cnt;
    int            t, row, src;
    bit            killed, e_we, e_done, e_lerr;
    logic [AW-1:0] e_aa, e_ab;
    logic [CW-1:0] e_slot [16];
    logic [CW-1:0] xv, yv;

    route_tab[0] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15};
    route_tab[1] = '{0, 2, 8, 10, 1, 3, 9, 11, 4, 6, 12, 14, 5, 7, 13, 15};
    route_tab[2] = '{0, 1, 8, 9, 2, 3, 10, 11, 4, 5, 12, 13, 6, 7, 14, 15};
    route_tab[3] = '{0, 8, 1, 9, 2, 3, 10, 11, 4, 5, 12, 13, 6, 7, 14, 15};
    bad_lens     = '{8'd0, 8'd1, 8'd3, 8'd96, 8'd255, 8'd12};

    for (int c = 0; c < NCYC; c++) begin
      p_rst[c] = 0; p_valid[c] = 0; p_ntt[c] = 0; p_flush[c] = 0;
      p_len[c] = 8'($urandom_range(0, 255));
      p_aa[c]  = AW'($urandom); p_ab[c] = AW'($urandom);
      for (int k = 0; k < 8; k++) begin
        p_ant[c][k] = CW'($urandom); p_bnt[c][k] = CW'($urandom);
        p_ait[c][k] = CW'($urandom); p_bit[c][k] = CW'($urandom);
      end
    end
    // Reset held 3 cycles with beats offered.
    for (int c = 0; c < 3; c++) begin
      p_rst[c] = 1'b1;
      plan_beat(c, 8'd2, 1'b1, AW'(c), AW'(c + 1));
    end
    plan_beat(10, 8'd128, 1'b1, 5'd3, 5'd9);
    plan_beat(20, 8'd64, 1'b1, 5'd4, 5'd5);
    plan_beat(22, 8'd64, 1'b0, 5'd6, 5'd7);
    for (int k = 0; k < 8; k++) begin
      p_ant[24][k] = CW'(12'h100 + k); p_bnt[24][k] = CW'(12'h200 + k);
      p_ant[26][k] = CW'(12'h100 + k); p_bnt[26][k] = CW'(12'h200 + k);
      p_ait[26][k] = CW'(12'h300 + k); p_bit[26][k] = CW'(12'h340 + k);
    end
    p_flush[30] = 1'b1;
    for (int c = 32; c < 48; c++) plan_beat(c, 8'd2, c[0], AW'(c), AW'(c + 16));
    plan_beat(60, 8'd16, 1'b1, 5'd11, 5'd12);
    p_flush[62] = 1'b1;
    plan_beat(70, 8'd96, 1'b1, 5'd13, 5'd14);
    p_flush[80] = 1'b1;
    for (int c = 90; c < NCYC - 12; c++) begin
      if ($urandom_range(0, 9) < 7) begin
        if ($urandom_range(0, 9) == 0)
          plan_beat(c, bad_lens[$urandom_range(0, 5)], 1'($urandom), AW'($urandom), AW'($urandom));
        else
          plan_beat(c, 8'(1 << $urandom_range(1, 7)), 1'($urandom), AW'($urandom), AW'($urandom));
      end
      p_flush[c] = ($urandom_range(0, 99) < 3);
      p_rst[c]   = ($urandom_range(0, 99) == 0);
    end

    rst = 1'b1; valid = 1'b0; flush = 1'b0; is_ntt = 1'b0; len = 8'd0; addr_a = '0; addr_b = '0;
    for (int k = 0; k < 8; k++) begin
      a_ntt[k] = '0; b_ntt[k] = '0; a_intt[k] = '0; b_intt[k] = '0;
    end

    cnt = 0;
    for (int c = 0; c < NCYC; c++) begin
      @(posedge clk);
      #1;
      if (c >= 1) begin
        // A beat offered in cycle t appears in cycle t+LAT+1 unless reset/flush hit t..t+LAT.
        t = c - (LAT + 1);
        e_we = 0; e_done = 0; e_lerr = 0; e_aa = '0; e_ab = '0;
        for (int s = 0; s < 16; s++) e_slot[s] = '0;
        if (t >= 0 && p_valid[t]) begin
          killed = 0;
          for (int k = t; k < c; k++)
            if (p_rst[k] || p_flush[k]) killed = 1;
          if (!killed) begin
            if (len_ok(p_len[t])) begin
              e_we = 1; e_aa = p_aa[t]; e_ab = p_ab[t];
              row = tab_row(p_len[t]);
              for (int s = 0; s < 16; s++) begin
                src = route_tab[row][s];
                xv = p_ntt[t] ? p_ant[c-1][src % 8] : p_ait[c-1][src % 8];
                yv = p_ntt[t] ? p_bnt[c-1][src % 8] : p_bit[c-1][src % 8];
                e_slot[s] = (src < 8) ? xv : yv;
              end
              e_done = (cnt == BEATS - 1);
              cnt    = e_done ? 0 : cnt + 1;
            end else begin
              e_lerr = 1;
            end
          end
        end
        if (p_rst[c] || p_flush[c]) cnt = 0;

        check_eq($sformatf("we@%0d", c), 32'(we), 32'(e_we));
        check_eq($sformatf("layer_done@%0d", c), 32'(layer_done), 32'(e_done));
        check_eq($sformatf("len_err@%0d", c), 32'(len_err), 32'(e_lerr));
        check_eq($sformatf("waddr_a@%0d", c), 32'(waddr_a), 32'(e_aa));
        check_eq($sformatf("waddr_b@%0d", c), 32'(waddr_b), 32'(e_ab));
        for (int j = 0; j < 8; j++) begin
          check_eq($sformatf("wdata_a[%0d]@%0d", j, c), 32'(wdata_a[j]), 32'(e_slot[2*j]));
          check_eq($sformatf("wdata_b[%0d]@%0d", j, c), 32'(wdata_b[j]), 32'(e_slot[2*j+1]));
        end

        // Directed spot checks with values taken straight from the intended behaviour.
        if (c == 15) begin
          check_eq("lat_we", 32'(we), 32'd1);
          check_eq("lat_waddr_a", 32'(waddr_a), 32'd3);
        end
        if (c == 14 || c == 16) check_eq($sformatf("lat_quiet@%0d", c), 32'(we), 32'd0);
        if (c == 25) begin
          check_eq("route64_a1", 32'(wdata_a[1]), 32'h200);
          check_eq("route64_b2", 32'(wdata_b[2]), 32'h103);
          check_eq("route64_b7", 32'(wdata_b[7]), 32'h207);
        end
        if (c == 27) begin
          check_eq("intt64_a1", 32'(wdata_a[1]), 32'h340);
          check_eq("intt64_b2", 32'(wdata_b[2]), 32'h303);
          check_eq("intt64_b7", 32'(wdata_b[7]), 32'h347);
        end
        if (c == 52) check_eq("layer_done_16th", 32'(layer_done), 32'd1);
        if (c == 51) check_eq("layer_done_15th", 32'(layer_done), 32'd0);
        if (c == 65) check_eq("flushed_beat_we", 32'(we), 32'd0);
        if (c == 75) begin
          check_eq("len96_err", 32'(len_err), 32'd1);
          check_eq("len96_we", 32'(we), 32'd0);
        end

        if (e_we || e_lerr)
          $display("cyc %0d beat@%0d len=%0d ntt=%0b -> we=%0b done=%0b len_err=%0b waddr=%0h/%0h",
                   c, t, p_len[t], p_ntt[t], we, layer_done, len_err, waddr_a, waddr_b);
      end

      rst = p_rst[c]; valid = p_valid[c]; flush = p_flush[c]; is_ntt = p_ntt[c];
      len = p_len[c]; addr_a = p_aa[c]; addr_b = p_ab[c];
      for (int k = 0; k < 8; k++) begin
        a_ntt[k] = p_ant[c][k]; b_ntt[k] = p_bnt[c][k];
        a_intt[k] = p_ait[c][k]; b_intt[k] = p_bit[c][k];
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
